// File: rtl/bin2gray_stream.sv
// Streaming binary-to-Gray encoder with a 2-entry skid buffer, adjacency flag and
// emitted-word counter. Encoding happens at accept time, so buffered words carry their flag.
module bin2gray_stream #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_gray,
  output logic          out_adj,
  output logic [CW-1:0] word_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t         state, state_d;
  logic [W-1:0]   skid_gray;
  logic           skid_adj;
  logic [W-1:0]   prev_gray;
  logic           first;
  logic           accept, emit;
  logic           load_out, load_skid, out_from_skid;
  logic [W-1:0]   enc_gray;
  logic [W-1:0]   diff;
  logic           enc_adj;

  assign in_ready  = (state != TWO) && !clear;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // Exactly one differing bit: nonzero and a power of two.
  assign enc_gray = in_bin ^ (in_bin >> 1);
  assign diff     = enc_gray ^ prev_gray;
  assign enc_adj  = !first && (diff != '0) && ((diff & (diff - W'(1))) == '0);

  always_comb begin
    state_d       = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (emit && !accept) begin
          state_d = EMPTY;
        end else if (accept && emit) begin
          load_out = 1'b1;
        end
      end
      TWO: begin
        if (emit) begin
          out_from_skid = 1'b1;
          state_d       = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_gray  <= '0;
      out_adj   <= 1'b0;
      skid_gray <= '0;
      skid_adj  <= 1'b0;
      prev_gray <= '0;
      first     <= 1'b1;
      word_cnt  <= '0;
    end else if (clear) begin
      // Clear wins over any handshake in the same cycle; that emit is not counted.
      state    <= EMPTY;
      first    <= 1'b1;
      word_cnt <= '0;
    end else begin
      state <= state_d;
      if (emit) word_cnt <= word_cnt + CW'(1);
      if (accept) begin
        prev_gray <= enc_gray;
        first     <= 1'b0;
      end
      if (load_out) begin
        out_gray <= enc_gray;
        out_adj  <= enc_adj;
      end else if (out_from_skid) begin
        out_gray <= skid_gray;
        out_adj  <= skid_adj;
      end
      if (load_skid) begin
        skid_gray <= enc_gray;
        skid_adj  <= enc_adj;
      end
    end
  end

endmodule

// File: tb/tb_bin2gray_stream.sv
// Directed self-checking bench for bin2gray_stream (W=4, CW=8) with immediate assertions.
module tb_bin2gray_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_bin = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_gray;
  logic       out_adj;
  logic [7:0] word_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  bin2gray_stream #(.W(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray),
    .out_adj(out_adj), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [3:0] exp_q [$];
  logic [3:0] exp_b;
  int emitted;
  int cycles;
  logic acc, emt;

  initial begin
    // Reset values
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_out_gray", 32'(out_gray), 32'd0);
    chk("rst_out_adj", 32'(out_adj), 32'd0);
    #10 rst_n = 1'b1;

    // 1: stream 0..15 back-to-back
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_bin = 4'(i);
      tick();
      chk("t1_gray", 32'(out_gray), 32'(gray_tab[i]));
      chk("t1_adj", 32'(out_adj), (i == 0) ? 32'd0 : 32'd1);
      chk("t1_cnt", 32'(word_cnt), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_cnt_end", 32'(word_cnt), 32'd16);
    chk("t1_valid_end", 32'(out_valid), 32'd0);

    // 2: backpressure, offer 5,6,7
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bin    = 4'd5;
    tick();
    chk("t2_gray5", 32'(out_gray), 32'b0111);
    chk("t2_rdy1", 32'(in_ready), 32'd1);
    in_bin = 4'd6;
    tick();
    chk("t2_rdy2", 32'(in_ready), 32'd0);
    chk("t2_stall_a", 32'(out_gray), 32'b0111);
    in_bin = 4'd7;
    tick();
    chk("t2_stall_b", 32'(out_gray), 32'b0111);
    chk("t2_stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t2_gray6", 32'(out_gray), 32'b0101);
    chk("t2_adj6", 32'(out_adj), 32'd1);
    chk("t2_cnt17", 32'(word_cnt), 32'd17);
    tick();
    chk("t2_gray7", 32'(out_gray), 32'b0100);
    chk("t2_adj7", 32'(out_adj), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("t2_cnt19", 32'(word_cnt), 32'd19);
    chk("t2_empty", 32'(out_valid), 32'd0);

    // 3: adjacency 3 then 12, then clear, then 0 and 5
    in_valid = 1'b1;
    in_bin   = 4'd3;
    tick();
    chk("t3_gray3", 32'(out_gray), 32'b0010);
    chk("t3_adj3", 32'(out_adj), 32'd0);
    in_bin = 4'd12;
    tick();
    chk("t3_gray12", 32'(out_gray), 32'b1010);
    chk("t3_adj12", 32'(out_adj), 32'd1);
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    chk("t3_clr_cnt", 32'(word_cnt), 32'd0);
    clear    = 1'b0;
    in_valid = 1'b1;
    in_bin   = 4'd0;
    tick();
    chk("t3_gray0", 32'(out_gray), 32'b0000);
    chk("t3_adj0", 32'(out_adj), 32'd0);
    in_bin = 4'd5;
    tick();
    chk("t3_gray5", 32'(out_gray), 32'b0111);
    chk("t3_adj5", 32'(out_adj), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("t3_cnt2", 32'(word_cnt), 32'd2);

    // 4: clear while TWO with out_ready=1
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bin    = 4'd1;
    tick();
    in_bin = 4'd2;
    tick();
    chk("t4_two", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear     = 1'b1;
    #1;
    chk("t4_rdy_clr", 32'(in_ready), 32'd0);
    tick();
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_cnt", 32'(word_cnt), 32'd0);
    clear = 1'b0;
    #1;
    chk("t4_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_bin   = 4'd4;
    tick();
    chk("t4_gray4", 32'(out_gray), 32'b0110);
    chk("t4_adj4", 32'(out_adj), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("t4_cnt1", 32'(word_cnt), 32'd1);

    // 5: async reset mid-cycle in TWO
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bin    = 4'd9;
    tick();
    in_bin = 4'd10;
    tick();
    in_valid = 1'b0;
    chk("t5_two", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_cnt", 32'(word_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bin    = 4'd6;
    tick();
    chk("t5_gray6", 32'(out_gray), 32'b0101);
    chk("t5_adj6", 32'(out_adj), 32'd0);
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_cnt_start", 32'(word_cnt), 32'd0);

    // 6: 256 words, random out_ready, decode check and counter wrap
    emitted = 0;
    cycles  = 0;
    while (emitted < 256 && cycles < 4000) begin
      in_valid  = (exp_q.size() + emitted < 256) ? 1'b1 : 1'b0;
      in_bin    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      emt = out_valid && out_ready;
      if (emt) begin
        exp_b = exp_q.pop_front();
        chk("t6_decode", 32'(g2b(out_gray)), 32'(exp_b));
        emitted++;
      end
      if (acc) exp_q.push_back(in_bin);
      tick();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t6_emitted", 32'(emitted), 32'd256);
    chk("t6_wrap", 32'(word_cnt), 32'd0);
    chk("t6_drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
